// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg
// Shared definitions for the load/store sequencer (mem_access_unit) and its
// lane logic (mau_lane):
//   - mau_state_t : sequencer states IDLE, READ, WRITE, DONE
//   - SZ_*        : access size encodings carried on the 'size' port
//   - is_word     : size decode (2'b11 is treated as a word access)
//   - eff_offset  : byte offset after forcing alignment for the access size
// -----------------------------------------------------------------------------
package mau_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } mau_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic is_word(input logic [1:0] size);
        return (size == SZ_WORD) || (size == 2'b11);
    endfunction

    // Halfwords ignore addr[0]; words ignore addr[1:0].
    function automatic logic [1:0] eff_offset(input logic [1:0] size,
                                              input logic [1:0] offset);
        logic [1:0] off;
        off = 2'b00;
        if (size == SZ_BYTE)
            off = offset;
        else if (size == SZ_HALF)
            off = {offset[1], 1'b0};
        return off;
    endfunction

endpackage

// File: rtl/mau_lane.sv
// -----------------------------------------------------------------------------
// mau_lane
// Combinational big-endian lane logic for the load/store sequencer.
//   ld_word  in  32  word read from memory (load extraction source)
//   st_word  in  32  previously captured word (read-modify-write source)
//   wdata    in  32  store data, right-justified for byte/half
//   offset   in  2   byte offset addr[1:0]
//   size     in  2   SZ_BYTE / SZ_HALF / SZ_WORD (11 = word)
//   sext     in  1   1 = sign-extend sub-word loads, 0 = zero-extend
//   rdata    out 32  extracted and extended load result
//   merged   out 32  write word: st_word with the target lane replaced
// Lane mapping: byte offset 0 -> [31:24] ... offset 3 -> [7:0];
//               half offset 0 -> [31:16], offset 2 -> [15:0].
// -----------------------------------------------------------------------------
import mau_pkg::*;

module mau_lane (
    input  logic [31:0] ld_word,
    input  logic [31:0] st_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign off = eff_offset(size, offset);

    always_comb begin
        ld_byte = 8'h00;
        ld_half = 16'h0000;
        rdata   = ld_word;
        merged  = wdata;

        case (off)
            2'd0:    ld_byte = ld_word[31:24];
            2'd1:    ld_byte = ld_word[23:16];
            2'd2:    ld_byte = ld_word[15:8];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = off[1] ? ld_word[15:0] : ld_word[31:16];

        if (size == SZ_BYTE) begin
            rdata  = {{24{sext & ld_byte[7]}}, ld_byte};
            merged = st_word;
            case (off)
                2'd0:    merged[31:24] = wdata[7:0];
                2'd1:    merged[23:16] = wdata[7:0];
                2'd2:    merged[15:8]  = wdata[7:0];
                default: merged[7:0]   = wdata[7:0];
            endcase
        end else if (size == SZ_HALF) begin
            rdata  = {{16{sext & ld_half[15]}}, ld_half};
            merged = st_word;
            if (off[1])
                merged[15:0]  = wdata[15:0];
            else
                merged[31:16] = wdata[15:0];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store sequencer between the multicycle datapath and a word-addressed
// data memory. One request at a time; sub-word stores are done as
// read-modify-write because the memory only supports whole-word writes.
//
// Build option: `define MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (IDLE -> DONE with err=1, no memory access). Without it, low
// address bits are ignored for alignment and err is always 0.
//
// Ports:
//   clk      in  1       clock, rising edge
//   reset    in  1       asynchronous active-high reset
//   req      in  1       request strobe, sampled only in IDLE
//   we       in  1       1 = store, 0 = load
//   size     in  2       00 byte, 01 half, 10/11 word
//   sext     in  1       sign-extend sub-word loads
//   addr     in  ADDR_W  byte address
//   wdata    in  32      store data (right-justified for sb/sh)
//   busy     out 1       state is not IDLE
//   done     out 1       one-cycle completion pulse
//   rdata    out 32      load result, held until the next load completes
//   err      out 1       misalignment flag, valid with done
//   mem_idx  out IDX_W   word index addr[IDX_W+1:2]
//   mem_we   out 1       memory write enable (only in WRITE)
//   mem_wd   out 32      memory write data
//   mem_rd   in  32      memory read data, combinational from mem_idx
// -----------------------------------------------------------------------------
import mau_pkg::*;

module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err,
    output logic [IDX_W-1:0]  mem_idx,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    mau_state_t state, state_next;

    logic [IDX_W+1:0] addr_r;
    logic             we_r;
    logic [1:0]       size_r;
    logic             sext_r;
    logic [31:0]      wdata_r;
    logic [31:0]      word_r;
    logic [31:0]      rdata_r;
    logic             err_r;
    logic             trap;
    logic             accept;
    logic [31:0]      lane_rdata;
    logic [31:0]      lane_merged;

    // Address bits above the memory range do not take part in the access.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W+2];

`ifdef MISALIGN_TRAP_EN
    assign trap = ((size == SZ_HALF) && addr[0]) ||
                  (is_word(size) && (addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign accept = (state == IDLE) && req;

    mau_lane u_lane (
        .ld_word (mem_rd),
        .st_word (word_r),
        .wdata   (wdata_r),
        .offset  (addr_r[1:0]),
        .size    (size_r),
        .sext    (sext_r),
        .rdata   (lane_rdata),
        .merged  (lane_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (trap)
                        state_next = DONE;
                    else if (we && is_word(size))
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:    state_next = we_r ? WRITE : DONE;
            WRITE:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Registers that are visible on outputs are cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r  <= '0;
            rdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            if (accept) begin
                addr_r <= addr[IDX_W+1:0];
                err_r  <= trap;
            end
            if ((state == READ) && !we_r)
                rdata_r <= lane_rdata;
        end
    end

    // Request payload and the read-modify-write word are only consumed
    // after being loaded in this access, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_r    <= we;
            size_r  <= size;
            sext_r  <= sext;
            wdata_r <= wdata;
        end
        if (state == READ)
            word_r <= mem_rd;
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign err     = done & err_r;
    assign rdata   = rdata_r;
    assign mem_idx = addr_r[IDX_W+1:2];
    assign mem_we  = (state == WRITE);
    // lane_merged already equals wdata_r for word stores.
    assign mem_wd  = mem_we ? lane_merged : 32'h0;

endmodule
